uio_bus_scheduler: RTL and testbench
====================================

# uio_bus_scheduler

Shares the 8-bit bidirectional `uio` pad bus of a Tiny Tapeout user project between up to four internal requesters. It arbitrates round-robin and inserts a bus-turnaround cycle whenever the pad direction changes. It sequences each transfer through a fixed hold window, and it alone drives `uio_out`/`uio_oe` inside `tt_um_*` top-levels.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, legal range 1–4.
- `HOLD_CYCLES`, default 2: cycles the bus is driven or sampled per transfer, legal range ≥1.
- `TURN_CYCLES`, default 1: turnaround cycles with all pads released, legal range ≥1.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset. The top-level drives it from `~rst_n`.
- `ena`  in  1: when low, no new grant is issued.
- `req`  in  NUM_REQ: per-requester transfer request, level.
- `we`  in  NUM_REQ: 1 = write (drive pads), 0 = read (sample pads).
- `wdata`  in  NUM_REQ*8: write byte; requester i uses bits [8i+7:8i].
- `grant`  out  NUM_REQ: one-hot; high for the granted requester for the whole transfer.
- `done`  out  NUM_REQ: one-cycle completion pulse to the granted requester.
- `rdata`  out  8: last byte read from the pads.
- `busy`  out  1: high whenever the state is not IDLE.
- `uio_in`  in  8: pad input path.
- `uio_out`  out  8: pad output path.
- `uio_oe`  out  8: pad output enable (1 = output).

## Operation
- **States:** IDLE → (TURN) → XFER → DONE → IDLE.

**IDLE**
- If `ena` and `|req`, choose a winner round-robin, starting the search at pointer `ptr`.
- Latch the winner index, its `we` and its `wdata`, and set `grant`.
- Next state is TURN if the latched `we` ≠ `last_dir`, else XFER.
- If there is no request, or `ena` is low, stay in IDLE.

**TURN**
- `uio_oe` = 0x00 for exactly `TURN_CYCLES` cycles, then go to XFER.

**XFER**
- Lasts exactly `HOLD_CYCLES` cycles.
- Write: `uio_oe` = 0xFF and `uio_out` = the latched `wdata`.
- Read: `uio_oe` = 0x00, and on the last XFER edge `uio_in` is captured into `rdata`.

**DONE**
- Runs for one cycle: `done[winner]` = 1, `grant` = 0.
- `last_dir` ← latched `we`; `ptr` ← (winner+1) mod `NUM_REQ`.
- `uio_oe` and `uio_out` keep their XFER values, so there is no glitch before the next transfer.
- Then return to IDLE.

**Rules**
- The requester holds `req`, `we` and `wdata` until `done`.
- `wdata` changes after grant are ignored, because it is latched.
- Dropping `req` mid-transfer does not abort; the transfer completes and `done` still pulses.
- `ena` falling mid-transfer does not abort; the current transfer completes and no further grant is issued.
- `req` from a requester whose `done` is high this cycle is re-arbitrated only from IDLE. Transfers are therefore back-to-back with at least one IDLE cycle.
- Round-robin guarantee: with N requesters continuously requesting, each is granted once per N transfers.
- Direction after IDLE:
  - After a write, `uio_oe` stays 0xFF and `uio_out` stays at the last byte.
  - After a read, `uio_oe` stays 0x00.
- Indices ≥ `NUM_REQ` never win.

## Timing
- **Reset values:**
  - `grant`, `done`, `rdata`, `uio_out`, `uio_oe` are all 0.
  - `busy` = 0, `ptr` = 0.
  - `last_dir` = 0 (read), so the first write after reset takes a TURN.
- **Reset mid-transfer:** all outputs return to reset values on the first edge with `rst` high. No `done` is issued.
- **Latency:** `req` sampled at edge k in IDLE.
  - `grant` and `busy` are high from cycle k+1.
  - XFER occupies cycles k+1+T .. k+T+HOLD_CYCLES, where T = 0 or `TURN_CYCLES`.
  - `done` is high in cycle k+T+HOLD_CYCLES+1.
  - IDLE is reached again at cycle k+T+HOLD_CYCLES+2.
- **Read data:** `rdata` is valid in the `done` cycle and holds until the next read completes.
- **Output timing:** all outputs are registered; there is no combinational path from `req` or `uio_in` to any output.

## Structure
- Package `uio_sched_pkg` holds:
  - the state enum (IDLE, TURN, XFER, DONE);
  - the direction constants DIR_RD=0 and DIR_WR=1;
  - the width of the hold/turn counter.
- Sub-module `rr_arbiter`: combinational one-hot round-robin pick from `req` and `ptr`, parameterised by `NUM_REQ`.
- Registers live in the parent: FSM, cycle counter, latched winner, direction, data and pointer.

## Test plan
All scenarios use the defaults (`NUM_REQ`=2, `HOLD_CYCLES`=2, `TURN_CYCLES`=1).

1. **Reset:** hold `rst` 3 cycles with random inputs → every output is 0 and `busy`=0.
2. **Write with turnaround:** `req[0]`, `we[0]`=1, `wdata`=0xA5 sampled at edge k.
   - `grant`=01 from k+1.
   - `uio_oe`=0x00 in k+1.
   - `uio_oe`=0xFF and `uio_out`=0xA5 in k+2..k+3.
   - `done`=01 in k+4.
3. **Read after write:** `req[1]`, `we[1]`=0, `uio_in`=0x3C.
   - One TURN with `uio_oe`=0x00, then 2 XFER cycles.
   - `rdata`=0x3C in the `done` cycle.
   - A second consecutive read has no TURN; `done` comes 3 cycles after `req` is sampled.
4. **Contention:** both `req` held high with `we`=1 → grants alternate 01, 10, 01, 10 across four transfers, each separated by one IDLE cycle.
5. **Gating:** `ena`=0 with `req`=11 for 10 cycles → `grant` stays 0. `ena` dropped mid-XFER → the transfer completes, then there is no new grant.
6. **Reset mid-XFER:** `rst` asserted during XFER → the next cycle has `uio_oe`=0, `grant`=0, no `done`, and the FSM is in IDLE.

Source files
------------

// File: rtl/uio_sched_pkg.sv
// Shared types and constants for the uio pad-bus scheduler.
// State encoding, direction values, counter width, one-hot helper.
package uio_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TURN,
    S_XFER,
    S_DONE
  } state_e;

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

  localparam int CNT_W = 8;
  localparam int IDX_W = 2;

  function automatic logic [IDX_W-1:0] oh2idx(
    input logic [3:0] oh
  );
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/uio_bus_scheduler_rr_arbiter.sv
// Round-robin one-hot pick: search starts at ptr_i and wraps.
// Purely combinational; the parent registers the result.
module rr_arbiter
  import uio_sched_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic found;

  // First requester at or after the pointer wins.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_i[i] &&
            ((int'(ptr_i) + off) % NUM_REQ) == i) begin
          gnt_o[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uio_bus_scheduler.sv
// Shares the uio pad bus between requesters: round-robin grant,
// turnaround on direction change, fixed hold window per transfer.
module uio_bus_scheduler
  import uio_sched_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int HOLD_CYCLES = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   we,
  input  logic [NUM_REQ*8-1:0] wdata,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic [7:0]           rdata,
  output logic                 busy,
  input  logic [7:0]           uio_in,
  output logic [7:0]           uio_out,
  output logic [7:0]           uio_oe
);

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LAST =
    CNT_W'(TURN_CYCLES - 1);

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     win_q;
  logic [IDX_W-1:0]     ptr_q;
  logic                 we_q;
  logic [7:0]           wd_q;
  logic                 dir_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [NUM_REQ-1:0]   done_q;
  logic [7:0]           rdata_q;
  logic                 busy_q;
  logic [7:0]           out_q;
  logic [7:0]           oe_q;

  logic [NUM_REQ-1:0]   pick_d;
  logic [IDX_W-1:0]     win_d;
  logic                 win_we_d;
  logic [7:0]           win_wd_d;
  logic [IDX_W-1:0]     ptr_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_d)
  );

  assign win_d    = oh2idx(4'(pick_d));
  assign win_we_d = |(pick_d & we);
  assign ptr_d    = IDX_W'((int'(win_q) + 1) % NUM_REQ);

  // Select the winning requester's write byte.
  always_comb begin
    win_wd_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_d[i]) win_wd_d = wdata[8*i +: 8];
    end
  end

  // Transfer sequencer with registered pad and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      win_q   <= '0;
      ptr_q   <= '0;
      we_q    <= DIR_RD;
      wd_q    <= '0;
      dir_q   <= DIR_RD;
      grant_q <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      out_q   <= '0;
      oe_q    <= '0;
    end else begin
      done_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (ena && |req) begin
            grant_q <= pick_d;
            win_q   <= win_d;
            we_q    <= win_we_d;
            wd_q    <= win_wd_d;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            if (win_we_d != dir_q) begin
              state_q <= S_TURN;
              oe_q    <= 8'h00;
            end else begin
              state_q <= S_XFER;
              oe_q    <= {8{win_we_d}};
              if (win_we_d == DIR_WR) out_q <= win_wd_d;
            end
          end
        end
        S_TURN: begin
          if (cnt_q == TURN_LAST) begin
            cnt_q   <= '0;
            state_q <= S_XFER;
            oe_q    <= {8{we_q}};
            if (we_q == DIR_WR) out_q <= wd_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_XFER: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_q   <= '0;
            state_q <= S_DONE;
            grant_q <= '0;
            done_q  <= grant_q;
            dir_q   <= we_q;
            ptr_q   <= ptr_d;
            if (we_q == DIR_RD) rdata_q <= uio_in;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign uio_out = out_q;
  assign uio_oe  = oe_q;

endmodule

// File: tb/tb_uio_bus_scheduler.sv
// Bench for uio_bus_scheduler: transfer-timeline reference model
// compared every cycle, plus directed literal expectations.
module tb_uio_bus_scheduler;

  localparam int NREQ = 2;
  localparam int HOLD = 2;
  localparam int TURN = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [15:0] wdata;
  logic [1:0]  grant;
  logic [1:0]  done;
  logic [7:0]  rdata;
  logic        busy;
  logic [7:0]  uio_in;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;

  uio_bus_scheduler #(
    .NUM_REQ     (NREQ),
    .HOLD_CYCLES (HOLD),
    .TURN_CYCLES (TURN)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .req     (req),
    .we      (we),
    .wdata   (wdata),
    .grant   (grant),
    .done    (done),
    .rdata   (rdata),
    .busy    (busy),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a transfer is a timeline of t = 1.. cycles
  // after the grant edge: T turn cycles, HOLD xfer cycles, done.
  bit         started;
  bit         m_active;
  int         m_t;
  int         m_T;
  int         m_win;
  bit         m_we;
  logic [7:0] m_wd;
  bit         m_dir;
  int         m_ptr;
  logic [7:0] m_rdata;
  logic [7:0] m_lastwr;

  function automatic int pick_rr(input logic [1:0] rq,
                                 input int p);
    for (int off = 0; off < NREQ; off++) begin
      if (rq[(p + off) % NREQ]) return (p + off) % NREQ;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      m_active <= 1'b0;
      m_t      <= 0;
      m_dir    <= 1'b0;
      m_ptr    <= 0;
      m_rdata  <= 8'h00;
      m_lastwr <= 8'h00;
    end else if (m_active) begin
      m_t <= m_t + 1;
      if (m_t == m_T + HOLD) begin
        if (m_we) m_lastwr <= m_wd;
        else m_rdata <= uio_in;
        m_dir <= m_we;
        m_ptr <= (m_win + 1) % NREQ;
      end
      if (m_t == m_T + HOLD + 1) m_active <= 1'b0;
    end else if (ena && req != 2'b00) begin
      m_active <= 1'b1;
      m_t      <= 1;
      m_win    <= pick_rr(req, m_ptr);
      m_we     <= we[pick_rr(req, m_ptr)];
      m_wd     <= wdata[8*pick_rr(req, m_ptr) +: 8];
      m_T      <= (we[pick_rr(req, m_ptr)] != m_dir) ? TURN : 0;
    end
  end

  always @(negedge clk) begin
    logic [1:0] e_grant;
    logic [1:0] e_done;
    logic [7:0] e_oe;
    logic [7:0] e_out;
    if (started) begin
      e_grant = (m_active && m_t <= m_T + HOLD)
                ? 2'(1 << m_win) : 2'b00;
      e_done  = (m_active && m_t == m_T + HOLD + 1)
                ? 2'(1 << m_win) : 2'b00;
      if (m_active)
        e_oe = (m_t <= m_T) ? 8'h00 : {8{m_we}};
      else
        e_oe = {8{m_dir}};
      e_out = (m_active && m_t > m_T && m_we) ? m_wd : m_lastwr;
      chk("model_busy", 16'(busy), 16'(m_active));
      chk("model_grant", 16'(grant), 16'(e_grant));
      chk("model_done", 16'(done), 16'(e_done));
      chk("model_oe", 16'(uio_oe), 16'(e_oe));
      chk("model_out", 16'(uio_out), 16'(e_out));
      chk("model_rdata", 16'(rdata), 16'(m_rdata));
    end
  end

  logic [1:0] g_tr  [0:20];
  logic [7:0] oe_tr [0:20];
  logic [7:0] out_tr[0:20];
  logic [7:0] rd_done;

  // One transfer from requester r; returns one cycle after done.
  task automatic xfer(input int r, input bit w,
                      input logic [7:0] d, input logic [7:0] ui,
                      input int exp_lat);
    int n;
    int lat;
    req = 2'(1 << r);
    we[r] = w;
    wdata[8*r +: 8] = d;
    uio_in = ui;
    n = 0;
    lat = 0;
    while (lat == 0 && n < 20) begin
      @(posedge clk); #2;
      n++;
      g_tr[n]   = grant;
      oe_tr[n]  = uio_oe;
      out_tr[n] = uio_out;
      if (n == 1) wdata[8*r +: 8] = ~d;
      if (done[r]) begin
        lat = n;
        rd_done = rdata;
      end
    end
    chk("xfer_latency", 16'(lat), 16'(exp_lat));
    req = 2'b00;
    @(posedge clk); #2;
  endtask

  logic [1:0] seq[0:3];
  int         tim[0:3];
  int         cnt;
  int         cyc;
  logic [1:0] dseen;

  initial begin
    rst    = 1'b1;
    ena    = 1'($urandom);
    req    = 2'($urandom);
    we     = 2'($urandom);
    wdata  = 16'($urandom);
    uio_in = 8'($urandom);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_grant", 16'(grant), 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_oe", 16'(uio_oe), 16'h0);
    chk("rst_out", 16'(uio_out), 16'h0);
    chk("rst_rdata", 16'(rdata), 16'h0);
    rst = 1'b0;
    req = 2'b00;
    we  = 2'b00;
    ena = 1'b1;
    @(posedge clk); #2;

    // Write after reset takes a turnaround.
    xfer(0, 1'b1, 8'hA5, 8'h00, 4);
    chk("wr_grant_k1", 16'(g_tr[1]), 16'h1);
    chk("wr_oe_turn", 16'(oe_tr[1]), 16'h00);
    chk("wr_oe_k2", 16'(oe_tr[2]), 16'hFF);
    chk("wr_out_k2", 16'(out_tr[2]), 16'hA5);
    chk("wr_out_k3", 16'(out_tr[3]), 16'hA5);
    chk("wr_idle_oe", 16'(uio_oe), 16'hFF);
    chk("wr_idle_out", 16'(uio_out), 16'hA5);

    // Read after write, then a second read with no turnaround.
    xfer(1, 1'b0, 8'h11, 8'h3C, 4);
    chk("rd1_oe_turn", 16'(oe_tr[1]), 16'h00);
    chk("rd1_oe_xfer", 16'(oe_tr[2]), 16'h00);
    chk("rd1_rdata", 16'(rd_done), 16'h3C);
    xfer(1, 1'b0, 8'h22, 8'hC3, 3);
    chk("rd2_rdata", 16'(rd_done), 16'hC3);
    chk("rd_idle_oe", 16'(uio_oe), 16'h00);

    // Contention: both writing continuously.
    we    = 2'b11;
    wdata = 16'hB2B1;
    req   = 2'b11;
    cnt   = 0;
    cyc   = 0;
    while (cnt < 4 && cyc < 60) begin
      @(posedge clk); #2;
      cyc++;
      if (done != 2'b00) begin
        seq[cnt] = done;
        tim[cnt] = cyc;
        cnt++;
      end
    end
    req = 2'b00;
    chk("rr_count", 16'(cnt), 16'd4);
    if (cnt == 4) begin
      chk("rr_g0", 16'(seq[0]), 16'h1);
      chk("rr_g1", 16'(seq[1]), 16'h2);
      chk("rr_g2", 16'(seq[2]), 16'h1);
      chk("rr_g3", 16'(seq[3]), 16'h2);
      for (int i = 1; i < 4; i++)
        chk("rr_gap", 16'(tim[i] - tim[i-1]), 16'd4);
    end
    repeat (2) @(posedge clk);
    #2;

    // Gating: no grant while ena is low.
    ena = 1'b0;
    req = 2'b11;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      chk("gate_grant", 16'(grant), 16'h0);
    end
    ena = 1'b1;
    cyc = 0;
    while (grant == 2'b00 && cyc < 10) begin
      @(posedge clk); #2;
      cyc++;
    end
    chk("gate_win", 16'(grant), 16'h1);
    ena = 1'b0;
    dseen = 2'b00;
    cyc = 0;
    while (dseen == 2'b00 && cyc < 10) begin
      @(posedge clk); #2;
      cyc++;
      dseen = done;
    end
    chk("gate_done", 16'(dseen), 16'h1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      chk("gate_after", 16'(grant), 16'h0);
    end
    req = 2'b00;
    ena = 1'b1;
    @(posedge clk); #2;

    // Reset in the middle of a read transfer.
    we  = 2'b00;
    uio_in = 8'h77;
    req = 2'b10;
    cyc = 0;
    while (grant == 2'b00 && cyc < 10) begin
      @(posedge clk); #2;
      cyc++;
    end
    chk("mid_grant", 16'(grant), 16'h2);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    chk("mid_grant0", 16'(grant), 16'h0);
    chk("mid_oe0", 16'(uio_oe), 16'h00);
    chk("mid_busy0", 16'(busy), 16'h0);
    chk("mid_done0", 16'(done), 16'h0);
    chk("mid_rdata0", 16'(rdata), 16'h00);
    rst = 1'b0;
    req = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      chk("mid_nodone", 16'(done), 16'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
